// File: rtl/atomic_unit.sv
`default_nettype none
// ============================================================================
// Module   : atomic_unit
// Brief    : RV32A LR.W / SC.W / AMO*.W sequencer for the MEM-stage instruction
// Revision : 1.0 - initial release
// ============================================================================
module atomic_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_amo_valid,
    input  logic [3:0]      mem_amo_op,
    input  logic [XLEN-1:0] mem_amo_addr,
    input  logic [XLEN-1:0] mem_amo_rs2,
    input  logic            stall_pipl,
    input  logic            trap,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_ack,
    input  logic [XLEN-1:0] dbus_rdata,
    output logic [XLEN-1:0] amo_result,
    output logic            amo_result_valid,
    output logic            atomic_unit_stall,
    output logic            atomic_unit_hazard,
    output logic            amo_misaligned
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_WR   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [3:0] c_OP_LR   = 4'd0;
    localparam logic [3:0] c_OP_SC   = 4'd1;
    localparam logic [3:0] c_OP_SWAP = 4'd2;
    localparam logic [3:0] c_OP_ADD  = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_AND  = 4'd5;
    localparam logic [3:0] c_OP_OR   = 4'd6;
    localparam logic [3:0] c_OP_MIN  = 4'd7;
    localparam logic [3:0] c_OP_MAX  = 4'd8;
    localparam logic [3:0] c_OP_MINU = 4'd9;
    localparam logic [3:0] c_OP_MAXU = 4'd10;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_addr;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_new_val;
    logic [XLEN-1:0] r_result;
    logic            r_resv_valid;
    logic [XLEN-1:0] r_resv_addr;
    logic            r_abort;

    logic            w_aligned;
    logic            w_entry;
    logic            w_sc_hit;
    logic            w_needs_read;
    logic [XLEN-1:0] w_new_val;

    assign w_aligned    = (mem_amo_addr[1:0] == 2'b00);
    assign w_entry      = !reset && (r_state == c_IDLE) && mem_amo_valid && w_aligned && !trap;
    assign w_sc_hit     = r_resv_valid && (r_resv_addr == mem_amo_addr);
    assign w_needs_read = (mem_amo_op == c_OP_LR) ||
                          ((mem_amo_op >= c_OP_SWAP) && (mem_amo_op <= c_OP_MAXU));

    // Ties keep the old memory value; dbus_rdata is the old value on the RD ack.
    always_comb begin
        w_new_val = r_rs2;
        case (r_op)
            c_OP_ADD:  w_new_val = dbus_rdata + r_rs2;
            c_OP_XOR:  w_new_val = dbus_rdata ^ r_rs2;
            c_OP_AND:  w_new_val = dbus_rdata & r_rs2;
            c_OP_OR:   w_new_val = dbus_rdata | r_rs2;
            c_OP_MIN:  w_new_val = ($signed(r_rs2) < $signed(dbus_rdata)) ? r_rs2 : dbus_rdata;
            c_OP_MAX:  w_new_val = ($signed(r_rs2) > $signed(dbus_rdata)) ? r_rs2 : dbus_rdata;
            c_OP_MINU: w_new_val = (r_rs2 < dbus_rdata) ? r_rs2 : dbus_rdata;
            c_OP_MAXU: w_new_val = (r_rs2 > dbus_rdata) ? r_rs2 : dbus_rdata;
            default:   w_new_val = r_rs2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_addr       <= '0;
            r_op         <= '0;
            r_rs2        <= '0;
            r_new_val    <= '0;
            r_result     <= '0;
            r_resv_valid <= 1'b0;
            r_resv_addr  <= '0;
            r_abort      <= 1'b0;
        end else begin
            if (trap) begin
                r_resv_valid <= 1'b0;
            end
            case (r_state)
                c_IDLE: begin
                    r_abort <= 1'b0;
                    if (w_entry) begin
                        r_addr    <= mem_amo_addr;
                        r_op      <= mem_amo_op;
                        r_rs2     <= mem_amo_rs2;
                        r_new_val <= mem_amo_rs2;
                        if (w_needs_read) begin
                            r_state <= c_RD;
                        end else if (mem_amo_op == c_OP_SC) begin
                            // Every SC consumes the reservation, hit or miss.
                            r_resv_valid <= 1'b0;
                            r_state      <= w_sc_hit ? c_WR : c_DONE;
                            r_result     <= w_sc_hit ? '0 : XLEN'(1);
                        end else begin
                            r_state  <= c_DONE;
                            r_result <= '0;
                        end
                    end
                end
                c_RD: begin
                    if (trap) begin
                        r_abort <= 1'b1;
                    end
                    if (dbus_ack) begin
                        r_result  <= dbus_rdata;
                        r_new_val <= w_new_val;
                        if (r_abort || trap) begin
                            r_state <= c_IDLE;
                        end else if (r_op == c_OP_LR) begin
                            r_resv_valid <= 1'b1;
                            r_resv_addr  <= r_addr;
                            r_state      <= c_DONE;
                        end else begin
                            r_state <= c_WR;
                        end
                    end
                end
                c_WR: begin
                    if (trap) begin
                        r_abort <= 1'b1;
                    end
                    if (dbus_ack) begin
                        r_state <= (r_abort || trap) ? c_IDLE : c_DONE;
                    end
                end
                default: begin
                    if (trap || !stall_pipl) begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign dbus_req           = (r_state == c_RD) || (r_state == c_WR);
    assign dbus_we            = (r_state == c_WR);
    assign dbus_addr          = dbus_req ? r_addr : '0;
    assign dbus_wdata         = dbus_we ? r_new_val : '0;
    assign amo_result_valid   = (r_state == c_DONE);
    assign amo_result         = amo_result_valid ? r_result : '0;
    assign atomic_unit_hazard = (r_state == c_DONE);
    assign atomic_unit_stall  = dbus_req || w_entry;
    assign amo_misaligned     = !reset && (r_state == c_IDLE) && mem_amo_valid && !w_aligned;

endmodule
`default_nettype wire
